context_fetch: RTL and testbench
================================

CONTEXT_FETCH -- requirements
Module: context_fetch

Interface
REQ-001 Parameter DATA_W, default 32, context word width in bits.
REQ-002 Parameter MEM_AW, default 8, context memory address width; depth is 2**MEM_AW words.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 CP  input  16  context pointer value from the pointer counter.
REQ-006 cp_valid  input  1  CP holds a new pointer value this cycle.
REQ-007 advance  output  1  fetch accepts a pointer this cycle; drives the pointer counter's start input.
REQ-008 last_cp  input  16  pointer value of the final context in the program.
REQ-009 cfg_we  input  1  context memory write strobe.
REQ-010 cfg_addr  input  MEM_AW  context memory write address.
REQ-011 cfg_wdata  input  DATA_W  context memory write data.
REQ-012 ctx_valid  output  1  ctx_data and ctx_cp are valid.
REQ-013 ctx_ready  input  1  PE array accepts the presented context.
REQ-014 ctx_data  output  DATA_W  fetched context word.
REQ-015 ctx_cp  output  16  pointer value that ctx_data was fetched from.
REQ-016 done  output  1  final context has been delivered.

Function
REQ-017 A pointer SHALL be accepted when cp_valid && advance are both high in the same cycle.
REQ-018 The memory SHALL be read at CP[MEM_AW-1:0]; upper CP bits SHALL be ignored for addressing and carried unchanged to ctx_cp.
REQ-019 Memory read latency SHALL be 1 cycle: an accepted pointer occupies the in-flight stage for one cycle, then its word and pointer SHALL enter a 2-entry output FIFO.
REQ-020 advance SHALL equal (state==RUN) && (fifo_count + inflight < 2).
REQ-021 ctx_valid SHALL be high whenever the FIFO is non-empty; ctx_data and ctx_cp SHALL show the head entry.
REQ-022 A head entry SHALL be removed on ctx_valid && ctx_ready. ctx_data and ctx_cp SHALL stay stable while ctx_valid && !ctx_ready.
REQ-023 A FIFO push and a pop in the same cycle SHALL leave the count unchanged and lose no data.
REQ-024 A push when the FIFO is full SHALL be impossible by construction; REQ-020 guarantees this.
REQ-025 The memory write port SHALL write cfg_wdata to cfg_addr on cfg_we, in any state.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-027 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-028 IDLE -> RUN SHALL occur on the first cycle with cp_valid high; that cycle SHALL NOT accept a pointer.
REQ-029 RUN -> DONE SHALL occur on the cycle in which an entry with ctx_cp == last_cp is popped.
REQ-030 DONE SHALL hold until reset, with done=1 and advance=0.
REQ-031 Entries remaining after the last_cp entry SHALL still be presented and popped normally.
REQ-032 A CP value that reaches 16'hFFFF and then wraps to 0 SHALL be fetched like any other value; fetch SHALL use no wrap detection.
REQ-033 If CP is accepted with a value equal to last_cp, the accept SHALL NOT itself set done; done SHALL follow only the pop of that entry.

Reset
REQ-034 While RST_N=0 at a rising edge: state=IDLE, FIFO emptied, in-flight cleared, advance=0, ctx_valid=0, done=0, ctx_data=0, ctx_cp=0.
REQ-035 Reset mid-operation SHALL discard all in-flight and buffered contexts.
REQ-036 Memory contents SHALL NOT be affected by reset.

Verification
REQ-037 Load mem[0..3]=A0,A1,A2,A3; last_cp=3; cp_valid=1, CP=0,1,2,3 stepping on each advance; ctx_ready=1 -> ctx_data A0..A3 in order, first ctx_valid 2 cycles after the first accept, done=1 the cycle after A3 is popped.
REQ-038 Same load, ctx_ready=0 -> advance drops after 2 accepts; ctx_data holds A0 stable; no third pointer is accepted until ctx_ready returns.
REQ-039 FIFO full, then ctx_ready toggled 1/0 each cycle -> every word is delivered once, in order, with no duplicates or drops.
REQ-040 cfg_we to address 5 with 0xDEAD in the same cycle CP=5 is read -> old mem[5] is delivered; a refetch of CP=5 returns 0xDEAD.
REQ-041 RST_N=0 with 2 entries buffered -> next cycle ctx_valid=0, advance=0, done=0, state IDLE; memory still holds A0..A3.
REQ-042 CP=16'h0102 with MEM_AW=8 -> mem[0x02] is fetched and ctx_cp=16'h0102.

Source files
------------

// File: rtl/context_fetch.sv
// Context fetch stage: reads context words from a local memory at the incoming
// pointer and buffers them in a 2-entry FIFO toward the PE array.
module context_fetch #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [15:0]       CP,
  input  logic              cp_valid,
  output logic              advance,
  input  logic [15:0]       last_cp,
  input  logic              cfg_we,
  input  logic [MEM_AW-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              ctx_valid,
  input  logic              ctx_ready,
  output logic [DATA_W-1:0] ctx_data,
  output logic [15:0]       ctx_cp,
  output logic              done
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic              infl_q;
  logic [DATA_W-1:0] infl_data_q;
  logic [15:0]       infl_cp_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [15:0]       fifo_cp_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [2:0]        occupancy;
  logic              accept, push, pop;

  // Memory is not reset; a same-cycle read of a written address sees old data.
  always_ff @(posedge CLK) begin
    if (cfg_we) mem[cfg_addr] <= cfg_wdata;
  end

  // Counting the in-flight read keeps the FIFO from ever being overrun.
  assign occupancy = {1'b0, count_q} + {2'b00, infl_q};
  assign advance   = (state_q == RUN) && (occupancy < 3'd2);
  assign accept    = cp_valid && advance;
  assign push      = infl_q;
  assign ctx_valid = (count_q != 2'd0);
  assign pop       = ctx_valid && ctx_ready;
  assign ctx_data  = fifo_data_q[rd_ptr_q];
  assign ctx_cp    = fifo_cp_q[rd_ptr_q];
  assign done      = (state_q == DONE);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      IDLE:    if (cp_valid) state_d = RUN;
      RUN:     if (pop && (ctx_cp == last_cp)) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      infl_q      <= 1'b0;
      infl_data_q <= '0;
      infl_cp_q   <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_cp_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      infl_q  <= accept;
      if (accept) begin
        infl_data_q <= mem[CP[MEM_AW-1:0]];
        infl_cp_q   <= CP;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= infl_data_q;
        fifo_cp_q[wr_ptr_q]   <= infl_cp_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_context_fetch.sv
// Randomized bench for context_fetch, checked each cycle against a queue-based
// transaction model of the fetch pipeline and output FIFO.
module tb_context_fetch;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          RST_N;
  logic [15:0]   CP;
  logic          cp_valid;
  logic          advance;
  logic [15:0]   last_cp;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          ctx_valid;
  logic          ctx_ready;
  logic [DW-1:0] ctx_data;
  logic [15:0]   ctx_cp;
  logic          done;

  always #5 clk = ~clk;

  context_fetch #(.DATA_W(DW), .MEM_AW(AW)) dut (
    .CLK(clk), .RST_N(RST_N), .CP(CP), .cp_valid(cp_valid), .advance(advance),
    .last_cp(last_cp), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ctx_valid(ctx_valid), .ctx_ready(ctx_ready), .ctx_data(ctx_data),
    .ctx_cp(ctx_cp), .done(done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   cp;
  } entry_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} phase_e;

  entry_t        refFifo[$];
  entry_t        refInfl[$];
  logic [DW-1:0] refMem [2**AW];
  phase_e        refPhase = M_IDLE;
  bit            refClean = 1'b1;
  logic [15:0]   cpCtr = 16'h0;
  int            checks = 0;
  int            passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic applyStimulus(input logic rstN, input logic cpv, input logic [15:0] cp,
                               input logic rdy, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    RST_N     = rstN;
    cp_valid  = cpv;
    CP        = cp;
    ctx_ready = rdy;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
  endtask

  function automatic bit expAdvance();
    return (refPhase == M_RUN) && ((refFifo.size() + refInfl.size()) < 2);
  endfunction

  task automatic compareOutputs();
    checkOutput("advance", advance, expAdvance());
    checkOutput("ctx_valid", ctx_valid, refFifo.size() > 0);
    checkOutput("done", done, refPhase == M_DONE);
    if (refFifo.size() > 0) begin
      checkOutput("ctx_data", ctx_data, refFifo[0].data);
      checkOutput("ctx_cp", ctx_cp, refFifo[0].cp);
    end else if (refClean) begin
      checkOutput("ctx_data_rst", ctx_data, 0);
      checkOutput("ctx_cp_rst", ctx_cp, 0);
    end
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic updateModel();
    bit     acc;
    bit     popNow;
    entry_t popped;
    entry_t fetched;
    if (!RST_N) begin
      refPhase = M_IDLE;
      refFifo.delete();
      refInfl.delete();
      refClean = 1'b1;
    end else begin
      acc    = cp_valid && expAdvance();
      popNow = (refFifo.size() > 0) && ctx_ready;
      popped.data = '0;
      popped.cp   = '0;
      if (popNow) popped = refFifo.pop_front();
      if (refInfl.size() > 0) begin
        refFifo.push_back(refInfl.pop_front());
        refClean = 1'b0;
      end
      if (acc) begin
        fetched.data = refMem[CP[AW-1:0]];
        fetched.cp   = CP;
        refInfl.push_back(fetched);
        cpCtr = cpCtr + 16'd1;
      end
      if (refPhase == M_IDLE && cp_valid) refPhase = M_RUN;
      else if (refPhase == M_RUN && popNow && popped.cp == last_cp) refPhase = M_DONE;
    end
    if (cfg_we) refMem[cfg_addr] = cfg_wdata;
  endtask

  task automatic runCycle(input logic rstN, input int cpvP, input int rdyP,
                          input int weP, input int sameP);
    logic [AW-1:0] addr;
    addr = ($urandom_range(99) < sameP) ? cpCtr[AW-1:0] : AW'($urandom);
    @(negedge clk);
    applyStimulus(rstN, $urandom_range(99) < cpvP, cpCtr, $urandom_range(99) < rdyP,
                  rstN && ($urandom_range(99) < weP), addr, $urandom);
    compareOutputs();
    @(posedge clk);
    updateModel();
  endtask

  task automatic runEpisode(input logic [15:0] start, input logic [15:0] last,
                            input int cpvP, input int rdyP, input int weP, input int sameP,
                            input int stall, input int nCycles);
    for (int i = 0; i < 2; i++) runCycle(1'b0, 50, 50, 0, 0);
    cpCtr   = start;
    last_cp = last;
    for (int i = 0; i < nCycles; i++)
      runCycle(1'b1, cpvP, (i < stall) ? 0 : rdyP, weP, sameP);
  endtask

  initial begin
    logic [15:0] s;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, '0, '0);
    last_cp = 16'h3;
    for (int i = 0; i < 3; i++) runCycle(1'b0, 0, 0, 0, 0);

    // Fill the whole context memory while the block sits in IDLE.
    for (int a = 0; a < 2**AW; a++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, AW'(a),
                    (a < 4) ? (32'hA0 + 32'(a)) : $urandom);
      compareOutputs();
      @(posedge clk);
      updateModel();
    end

    runEpisode(16'h0000, 16'h0003, 100, 100, 0, 0, 0, 20);
    runEpisode(16'h0000, 16'h0003, 100, 100, 0, 0, 12, 20);
    runEpisode(16'h0000, 16'h0007, 100, 50, 30, 60, 0, 40);
    runEpisode(16'h0005, 16'h0006, 100, 70, 60, 90, 0, 30);
    runEpisode(16'hFFFE, 16'h0001, 90, 70, 0, 0, 0, 30);
    runEpisode(16'h0102, 16'h0105, 90, 70, 0, 0, 0, 30);
    for (int e = 0; e < 20; e++) begin
      s = 16'($urandom);
      runEpisode(s, s + 16'($urandom_range(0, 6)), 70, 60, 20, 40,
                 $urandom_range(0, 5), 40);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
